// File: rtl/io_periph_pkg.sv
// Shared MMIO address map, decode types and helpers for the I/O peripheral.
// Key debouncing is selected at build time with IO_KEY_DEBOUNCE_EN.
package io_periph_pkg;

    localparam int unsigned ADDR_W  = 16;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned NUM_HEX = 8;
    localparam int unsigned NUM_LCD = 8;

    localparam logic [ADDR_W-1:0] LEDR_ADDR        = 16'h7000;
    localparam logic [ADDR_W-1:0] LEDG_ADDR        = 16'h7010;
    localparam logic [ADDR_W-1:0] HEX_BASE         = 16'h7020;
    localparam logic [ADDR_W-1:0] LCD_BASE         = 16'h7040;
    localparam logic [ADDR_W-1:0] SW_ADDR          = 16'h7800;
    localparam logic [ADDR_W-1:0] KEY_ADDR         = 16'h7810;
    localparam logic [ADDR_W-1:0] MMIO_REGION_MASK = 16'hF000;
    localparam logic [ADDR_W-1:0] MMIO_REGION_BASE = 16'h7000;

    typedef enum logic [2:0] {
        REG_NONE,
        REG_LEDR,
        REG_LEDG,
        REG_HEX,
        REG_LCD,
        REG_SW,
        REG_KEY
    } io_reg_e;

    typedef struct packed {
        io_reg_e    kind;
        logic [2:0] idx;
    } io_sel_t;

    // Word-aligned address decode; HEX/LCD banks are eight consecutive words.
    function automatic io_sel_t io_decode(input logic [ADDR_W-1:0] addr);
        logic [ADDR_W-1:0] a;
        io_sel_t           sel;
        a        = {addr[ADDR_W-1:2], 2'b00};
        sel.kind = REG_NONE;
        sel.idx  = addr[4:2];
        if ((a & MMIO_REGION_MASK) == MMIO_REGION_BASE) begin
            if (a == LEDR_ADDR)                      sel.kind = REG_LEDR;
            else if (a == LEDG_ADDR)                 sel.kind = REG_LEDG;
            else if (a[ADDR_W-1:5] == HEX_BASE[ADDR_W-1:5]) sel.kind = REG_HEX;
            else if (a[ADDR_W-1:5] == LCD_BASE[ADDR_W-1:5]) sel.kind = REG_LCD;
            else if (a == SW_ADDR)                   sel.kind = REG_SW;
            else if (a == KEY_ADDR)                  sel.kind = REG_KEY;
        end
        return sel;
    endfunction

    function automatic logic [DATA_W-1:0] byte_merge(input logic [DATA_W-1:0] old_val,
                                                     input logic [DATA_W-1:0] wdata,
                                                     input logic [3:0]        bmask);
        logic [DATA_W-1:0] res;
        res = old_val;
        for (int b = 0; b < 4; b++) begin
            if (bmask[b]) res[8*b +: 8] = wdata[8*b +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/io_debounce.sv
// Two-flop synchroniser with optional per-bit stable-count debounce.
// Counters exist only when IO_KEY_DEBOUNCE_EN is defined.
module io_debounce #(
    parameter int unsigned WIDTH           = 32,
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= d_i;
            r_sync <= r_meta;
        end
    end

`ifdef IO_KEY_DEBOUNCE_EN
    localparam int unsigned     CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] r_cnt [WIDTH];
    logic [WIDTH-1:0] r_val;

    // Commit a bit only after it disagrees for DEBOUNCE_CYCLES consecutive edges.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_val <= '0;
            for (int i = 0; i < int'(WIDTH); i++) r_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < int'(WIDTH); i++) begin
                if (r_sync[i] != r_val[i]) begin
                    if (r_cnt[i] == CNT_LAST) begin
                        r_val[i] <= r_sync[i];
                        r_cnt[i] <= '0;
                    end else begin
                        r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                    end
                end else begin
                    r_cnt[i] <= '0;
                end
            end
        end
    end

    assign q_o = r_val;
`else
    // Debounce length has no effect without the counters.
    localparam int unsigned unused_debounce_cycles = DEBOUNCE_CYCLES;

    assign q_o = r_sync;
`endif

endmodule

// File: rtl/io_periph.sv
// Memory-mapped LED/HEX/LCD output registers plus synchronised SW/KEY inputs.
// Define IO_KEY_DEBOUNCE_EN to debounce KEY; SW is only synchronised.
module io_periph
    import io_periph_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [15:0] addr_i,
    input  logic        wren_i,
    input  logic [31:0] wdata_i,
    input  logic [3:0]  bmask_i,
    output logic [31:0] rdata_o,
    output logic        hit_o,
    input  logic [31:0] io_sw_i,
    input  logic [31:0] io_key_i,
    output logic [31:0] io_ledr_o,
    output logic [31:0] io_ledg_o,
    output logic [31:0] io_hex0_o,
    output logic [31:0] io_hex1_o,
    output logic [31:0] io_hex2_o,
    output logic [31:0] io_hex3_o,
    output logic [31:0] io_hex4_o,
    output logic [31:0] io_hex5_o,
    output logic [31:0] io_hex6_o,
    output logic [31:0] io_hex7_o,
    output logic [31:0] io_lcd0_o,
    output logic [31:0] io_lcd1_o,
    output logic [31:0] io_lcd2_o,
    output logic [31:0] io_lcd3_o,
    output logic [31:0] io_lcd4_o,
    output logic [31:0] io_lcd5_o,
    output logic [31:0] io_lcd6_o,
    output logic [31:0] io_lcd7_o
);

    io_sel_t     w_sel;
    logic [31:0] w_key_val;
    logic [31:0] r_ledr;
    logic [31:0] r_ledg;
    logic [31:0] r_hex [NUM_HEX];
    logic [31:0] r_lcd [NUM_LCD];
    logic [31:0] r_sw_meta;
    logic [31:0] r_sw_sync;

    assign w_sel = io_decode(addr_i);

    // Byte-masked stores; SW, KEY and misses fall through untouched.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_ledr <= '0;
            r_ledg <= '0;
            for (int i = 0; i < int'(NUM_HEX); i++) r_hex[i] <= '0;
            for (int i = 0; i < int'(NUM_LCD); i++) r_lcd[i] <= '0;
        end else if (wren_i) begin
            case (w_sel.kind)
                REG_LEDR: r_ledr             <= byte_merge(r_ledr, wdata_i, bmask_i);
                REG_LEDG: r_ledg             <= byte_merge(r_ledg, wdata_i, bmask_i);
                REG_HEX:  r_hex[w_sel.idx]   <= byte_merge(r_hex[w_sel.idx], wdata_i, bmask_i);
                REG_LCD:  r_lcd[w_sel.idx]   <= byte_merge(r_lcd[w_sel.idx], wdata_i, bmask_i);
                default:  ;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_sw_meta <= '0;
            r_sw_sync <= '0;
        end else begin
            r_sw_meta <= io_sw_i;
            r_sw_sync <= r_sw_meta;
        end
    end

    io_debounce #(
        .WIDTH           (32),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_key_db (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .d_i    (io_key_i),
        .q_o    (w_key_val)
    );

    // Load path is address-only so the core can use it within its single cycle.
    always_comb begin
        rdata_o = '0;
        hit_o   = (w_sel.kind != REG_NONE);
        case (w_sel.kind)
            REG_LEDR: rdata_o = r_ledr;
            REG_LEDG: rdata_o = r_ledg;
            REG_HEX:  rdata_o = r_hex[w_sel.idx];
            REG_LCD:  rdata_o = r_lcd[w_sel.idx];
            REG_SW:   rdata_o = r_sw_sync;
            REG_KEY:  rdata_o = w_key_val;
            default:  rdata_o = '0;
        endcase
    end

    assign io_ledr_o = r_ledr;
    assign io_ledg_o = r_ledg;
    assign io_hex0_o = r_hex[0];
    assign io_hex1_o = r_hex[1];
    assign io_hex2_o = r_hex[2];
    assign io_hex3_o = r_hex[3];
    assign io_hex4_o = r_hex[4];
    assign io_hex5_o = r_hex[5];
    assign io_hex6_o = r_hex[6];
    assign io_hex7_o = r_hex[7];
    assign io_lcd0_o = r_lcd[0];
    assign io_lcd1_o = r_lcd[1];
    assign io_lcd2_o = r_lcd[2];
    assign io_lcd3_o = r_lcd[3];
    assign io_lcd4_o = r_lcd[4];
    assign io_lcd5_o = r_lcd[5];
    assign io_lcd6_o = r_lcd[6];
    assign io_lcd7_o = r_lcd[7];

endmodule

// File: tb/tb_io_periph.sv
// Self-checking bench for io_periph: directed vector table, random traffic
// against an address-map model, and multi-cycle sync/debounce/reset sequences.
module tb_io_periph;

    localparam int unsigned DEB = 16;

    logic        clk;
    logic        rst_n;
    logic [15:0] addr;
    logic        wren;
    logic [31:0] wdata;
    logic [3:0]  bmask;
    logic [31:0] rdata;
    logic        hit;
    logic [31:0] sw;
    logic [31:0] key;
    logic [31:0] ledr;
    logic [31:0] ledg;
    logic [31:0] hex_o [8];
    logic [31:0] lcd_o [8];

    io_periph #(.DEBOUNCE_CYCLES(DEB)) dut (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .addr_i    (addr),
        .wren_i    (wren),
        .wdata_i   (wdata),
        .bmask_i   (bmask),
        .rdata_o   (rdata),
        .hit_o     (hit),
        .io_sw_i   (sw),
        .io_key_i  (key),
        .io_ledr_o (ledr),
        .io_ledg_o (ledg),
        .io_hex0_o (hex_o[0]),
        .io_hex1_o (hex_o[1]),
        .io_hex2_o (hex_o[2]),
        .io_hex3_o (hex_o[3]),
        .io_hex4_o (hex_o[4]),
        .io_hex5_o (hex_o[5]),
        .io_hex6_o (hex_o[6]),
        .io_hex7_o (hex_o[7]),
        .io_lcd0_o (lcd_o[0]),
        .io_lcd1_o (lcd_o[1]),
        .io_lcd2_o (lcd_o[2]),
        .io_lcd3_o (lcd_o[3]),
        .io_lcd4_o (lcd_o[4]),
        .io_lcd5_o (lcd_o[5]),
        .io_lcd6_o (lcd_o[6]),
        .io_lcd7_o (lcd_o[7])
    );

    always #5 clk = ~clk;

    int n_vec;
    int n_err;

    // Reference model: register file by address, inputs delayed two edges.
    logic [31:0] m_ledr;
    logic [31:0] m_ledg;
    logic [31:0] m_hex [8];
    logic [31:0] m_lcd [8];
    logic [31:0] sw_q[$];
    logic [31:0] key_q[$];
    logic [31:0] m_key_val;

    typedef struct {
        logic [15:0] addr;
        logic        wr;
        logic [31:0] wdata;
        logic [3:0]  bmask;
        logic        hit;
        logic [31:0] rd;
    } vec_t;

    vec_t        tbl [16];
    logic [15:0] map_list [18];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_ledr = '0;
        m_ledg = '0;
        for (int i = 0; i < 8; i++) begin
            m_hex[i] = '0;
            m_lcd[i] = '0;
        end
        sw_q  = {32'h0, 32'h0};
        key_q = {32'h0, 32'h0};
        m_key_val = '0;
    endtask

    function automatic logic [31:0] model_key();
`ifdef IO_KEY_DEBOUNCE_EN
        return m_key_val;
`else
        return key_q[0];
`endif
    endfunction

    function automatic logic [32:0] model_read(input logic [15:0] a_in);
        int unsigned a;
        a = int'(a_in) & 32'hFFFC;
        if (a == 32'h7000) return {1'b1, m_ledr};
        if (a == 32'h7010) return {1'b1, m_ledg};
        if (a >= 32'h7020 && a < 32'h7040) return {1'b1, m_hex[(a - 32'h7020) / 4]};
        if (a >= 32'h7040 && a < 32'h7060) return {1'b1, m_lcd[(a - 32'h7040) / 4]};
        if (a == 32'h7800) return {1'b1, sw_q[0]};
        if (a == 32'h7810) return {1'b1, model_key()};
        return 33'h0;
    endfunction

    task automatic model_store(input logic [15:0] a_in, input logic [31:0] d, input logic [3:0] m);
        int unsigned a;
        logic [31:0] keep;
        a    = int'(a_in) & 32'hFFFC;
        keep = ~{{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
        if (a == 32'h7000) m_ledr = (m_ledr & keep) | (d & ~keep);
        else if (a == 32'h7010) m_ledg = (m_ledg & keep) | (d & ~keep);
        else if (a >= 32'h7020 && a < 32'h7040)
            m_hex[(a - 32'h7020) / 4] = (m_hex[(a - 32'h7020) / 4] & keep) | (d & ~keep);
        else if (a >= 32'h7040 && a < 32'h7060)
            m_lcd[(a - 32'h7040) / 4] = (m_lcd[(a - 32'h7040) / 4] & keep) | (d & ~keep);
    endtask

    task automatic check_outputs(input string tag);
        check({tag, " ledr"}, ledr, m_ledr);
        check({tag, " ledg"}, ledg, m_ledg);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("%s hex%0d", tag, i), hex_o[i], m_hex[i]);
            check($sformatf("%s lcd%0d", tag, i), lcd_o[i], m_lcd[i]);
        end
    endtask

    // One bus cycle: drive at negedge, check load path, clock, check outputs.
    task automatic step(input logic [15:0] a, input logic w, input logic [31:0] d,
                        input logic [3:0] m, input logic [32:0] exp_rd, input string tag);
        @(negedge clk);
        addr  = a;
        wren  = w;
        wdata = d;
        bmask = m;
        #1;
        check({tag, " hit"}, 32'(hit), 32'(exp_rd[32]));
        check({tag, " rdata"}, rdata, exp_rd[31:0]);
        @(posedge clk);
        if (w) model_store(a, d, m);
        sw_q.push_back(sw);
        void'(sw_q.pop_front());
        key_q.push_back(key);
        void'(key_q.pop_front());
        #1;
        check_outputs(tag);
        wren = 1'b0;
    endtask

    initial begin
        logic [15:0] a;
        n_vec = 0;
        n_err = 0;
        clk   = 1'b0;
        rst_n = 1'b0;
        addr  = '0;
        wren  = 1'b0;
        wdata = '0;
        bmask = '0;
        sw    = '0;
        key   = '0;
        model_reset();

        tbl[0]  = '{16'h7000, 1'b1, 32'hDEADBEEF, 4'hF,    1'b1, 32'h0};
        tbl[1]  = '{16'h7000, 1'b0, 32'h0,        4'h0,    1'b1, 32'hDEADBEEF};
        tbl[2]  = '{16'h7013, 1'b1, 32'h12345678, 4'b0011, 1'b1, 32'h0};
        tbl[3]  = '{16'h7010, 1'b0, 32'h0,        4'h0,    1'b1, 32'h00005678};
        tbl[4]  = '{16'h702C, 1'b1, 32'h11223344, 4'hF,    1'b1, 32'h0};
        tbl[5]  = '{16'h702C, 1'b1, 32'hAABBCCDD, 4'b0100, 1'b1, 32'h11223344};
        tbl[6]  = '{16'h702E, 1'b0, 32'h0,        4'h0,    1'b1, 32'h11BB3344};
        tbl[7]  = '{16'h705C, 1'b1, 32'hCAFEF00D, 4'b1001, 1'b1, 32'h0};
        tbl[8]  = '{16'h705C, 1'b0, 32'h0,        4'h0,    1'b1, 32'hCA00000D};
        tbl[9]  = '{16'h7800, 1'b1, 32'hFFFFFFFF, 4'hF,    1'b1, 32'h0};
        tbl[10] = '{16'h7100, 1'b1, 32'hFFFFFFFF, 4'hF,    1'b0, 32'h0};
        tbl[11] = '{16'h7100, 1'b0, 32'h0,        4'h0,    1'b0, 32'h0};
        tbl[12] = '{16'h7060, 1'b1, 32'h55555555, 4'hF,    1'b0, 32'h0};
        tbl[13] = '{16'h701C, 1'b0, 32'h0,        4'h0,    1'b0, 32'h0};
        tbl[14] = '{16'h7810, 1'b1, 32'hFFFFFFFF, 4'hF,    1'b1, 32'h0};
        tbl[15] = '{16'h6000, 1'b1, 32'hFFFFFFFF, 4'hF,    1'b0, 32'h0};

        map_list[0]  = 16'h7000;
        map_list[1]  = 16'h7010;
        for (int i = 0; i < 8; i++) begin
            map_list[2 + i]  = 16'h7020 + 16'(4 * i);
            map_list[10 + i] = 16'h7040 + 16'(4 * i);
        end

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        addr = 16'h7000;
        #1;
        check_outputs("reset");
        check("reset rdata", rdata, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            step(tbl[i].addr, tbl[i].wr, tbl[i].wdata, tbl[i].bmask,
                 {tbl[i].hit, tbl[i].rd}, $sformatf("vec%0d", i));
        end

        // Random traffic against the model
        for (int n = 0; n < 300; n++) begin
            sw = $urandom;
`ifndef IO_KEY_DEBOUNCE_EN
            key = $urandom;
`endif
            case ($urandom_range(0, 3))
                0:       a = map_list[$urandom_range(0, 17)] | 16'($urandom_range(0, 3));
                1:       a = 16'h7000 + 16'($urandom_range(0, 127));
                2:       a = 16'h7800 + 16'($urandom_range(0, 31));
                default: a = 16'($urandom);
            endcase
            step(a, 1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)),
                 model_read(a), "rnd");
        end

        sw  = '0;
        key = '0;
        repeat (3) step(16'h7800, 1'b0, 32'h0, 4'h0, model_read(16'h7800), "settle");

        // Masked store into HEX3
        step(16'h702C, 1'b1, 32'h11223344, 4'hF, model_read(16'h702C), "hex3 init");
        step(16'h702C, 1'b1, 32'hAABBCCDD, 4'b0100, {1'b1, 32'h11223344}, "hex3 mask");
        check("hex3 merged", hex_o[3], 32'h11BB3344);

        // Stores to read-only and unmapped addresses
        step(16'h7800, 1'b1, 32'hFFFFFFFF, 4'hF, {1'b1, 32'h0}, "sw store");
        step(16'h7100, 1'b1, 32'hFFFFFFFF, 4'hF, {1'b0, 32'h0}, "unmapped store");
        step(16'h7100, 1'b0, 32'h0, 4'h0, {1'b0, 32'h0}, "unmapped load");

        // Switch synchroniser: visible two edges after the change
        sw = 32'h0000_0155;
        step(16'h7800, 1'b0, 32'h0, 4'h0, {1'b1, 32'h0},   "sw edge0");
        step(16'h7800, 1'b0, 32'h0, 4'h0, {1'b1, 32'h0},   "sw edge1");
        step(16'h7800, 1'b0, 32'h0, 4'h0, {1'b1, 32'h155}, "sw edge2");

`ifdef IO_KEY_DEBOUNCE_EN
        key = 32'h1;
        repeat (5) step(16'h7810, 1'b0, 32'h0, 4'h0, {1'b1, 32'h0}, "key glitch");
        key = 32'h0;
        repeat (25) step(16'h7810, 1'b0, 32'h0, 4'h0, {1'b1, 32'h0}, "key glitch after");
        key = 32'h1;
        for (int k = 1; k <= int'(DEB) + 3; k++) begin
            step(16'h7810, 1'b0, 32'h0, 4'h0,
                 {1'b1, (k > int'(DEB) + 2) ? 32'h1 : 32'h0}, $sformatf("key step e%0d", k - 1));
        end
        m_key_val = 32'h1;
`else
        key = 32'h1;
        step(16'h7810, 1'b0, 32'h0, 4'h0, {1'b1, 32'h0}, "key edge0");
        step(16'h7810, 1'b0, 32'h0, 4'h0, {1'b1, 32'h0}, "key edge1");
        step(16'h7810, 1'b0, 32'h0, 4'h0, {1'b1, 32'h1}, "key edge2");
`endif

        // Read-during-write returns the old value
        step(16'h7010, 1'b1, 32'h1, 4'hF, model_read(16'h7010), "rdw init");
        step(16'h7010, 1'b1, 32'h2, 4'hF, {1'b1, 32'h1}, "rdw same");
        step(16'h7010, 1'b0, 32'h0, 4'h0, {1'b1, 32'h2}, "rdw next");

        // Asynchronous reset mid-run, checked before any clock edge
        step(16'h7000, 1'b1, 32'hDEADBEEF, 4'hF, model_read(16'h7000), "pre reset");
        addr  = 16'h7000;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs("async reset");
        check("async reset rdata", rdata, 32'h0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step(16'h7000, 1'b1, 32'h5, 4'hF, model_read(16'h7000), "post reset");
        step(16'h7000, 1'b0, 32'h0, 4'h0, {1'b1, 32'h5}, "post reset rd");
        repeat (3) step(16'h7800, 1'b0, 32'h0, 4'h0, model_read(16'h7800), "post reset sw");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/io_periph.md
# io_periph

Memory-mapped I/O peripheral unit for the single-cycle RV32I core. It sits directly downstream of the core's load/store address path, beside the data memory. It decodes word-aligned MMIO addresses and owns the LEDR, LEDG, HEX0–7 and LCD0–7 output registers, with byte-masked stores. It also synchronises, and optionally debounces, the switch and key inputs so the core can read them combinationally within its single cycle.

## Interface
- DEBOUNCE_CYCLES, default 16, is the number of consecutive stable cycles required before a debounced key bit changes; the legal range is 2..65535.
- clk_i, input, 1 bit: the single clock. All state updates on its rising edge.
- rst_ni, input, 1 bit: asynchronous, active-low reset.
- addr_i, input, 16 bits: byte address from the ALU result. Bits [1:0] are ignored for decode.
- wren_i, input, 1 bit: store strobe for the current instruction.
- wdata_i, input, 32 bits: store data, already lane-aligned.
- bmask_i, input, 4 bits: byte-lane enables. Bit n enables byte n.
- rdata_o, output, 32 bits: combinational load data for addr_i.
- hit_o, output, 1 bit: combinational flag, 1 when addr_i decodes to any MMIO register. The core's write-back mux uses it to choose rdata_o over data memory.
- io_sw_i, input, 32 bits: raw, asynchronous switch inputs.
- io_key_i, input, 32 bits: raw, asynchronous key inputs.
- io_ledr_o, io_ledg_o, output, 32 bits each: LED registers.
- io_hex0_o..io_hex7_o, output, 32 bits each: seven-segment registers.
- io_lcd0_o..io_lcd7_o, output, 32 bits each: LCD registers.

## Operation
- Address map, with the low 2 bits dropped before decode:
  - LEDR is at 0x7000.
  - LEDG is at 0x7010.
  - HEXn is at 0x7020 + 4n.
  - LCDn is at 0x7040 + 4n.
  - SW is at 0x7800 and is read-only.
  - KEY is at 0x7810 and is read-only.
  - Every other address misses: hit_o = 0 and rdata_o = 0.
- Store behaviour:
  - A store happens on a rising edge when wren_i = 1 and addr_i hits a writable register.
  - For each n, byte n of the register is replaced by wdata_i byte n only when bmask_i[n] = 1. All other bytes hold.
  - A store to SW, KEY or an unmapped address is ignored and no state changes.
- Load behaviour:
  - rdata_o is purely combinational: the current register value, sw_sync for SW, or key_val for KEY.
  - The bmask is not applied on reads. The core extracts the bytes it needs.
- Input path:
  - io_sw_i and io_key_i each pass through a 2-flop synchroniser, producing sw_sync and key_sync.
  - key_val is the debounced key value, or key_sync itself when debounce is compiled out (see Configuration).
- Debounce, per key bit:
  - Each bit has a stable counter.
  - When key_sync differs from key_val, the counter increments. Otherwise it clears to 0.
  - When the counter reaches DEBOUNCE_CYCLES−1 while key_sync still differs, key_val takes the new value on that edge and the counter clears.
  - Any glitch shorter than DEBOUNCE_CYCLES cycles never reaches key_val.
- Reset:
  - Every output register, both synchroniser stages, key_val and all counters are cleared to 0 immediately when rst_ni falls.
  - A store in flight during reset is lost.

## Timing
- Store to output pin: the new value appears at the output on the clock edge that ends the store cycle, so latency is 1 edge.
- Load and store to the same register in the same cycle: rdata_o shows the old value, and the new value is visible from the next cycle.
- Switch input to sw_sync: 2 edges.
- Key input to key_val:
  - With debounce compiled in: 2 + DEBOUNCE_CYCLES edges for a clean step.
  - Without debounce: 2 edges.
- Counter width is clog2(DEBOUNCE_CYCLES). It never wraps because it clears on a match or on a commit.
- hit_o and rdata_o depend on addr_i and registered state only, never on wren_i.

## Configuration
- The macro IO_KEY_DEBOUNCE_EN controls key debouncing.
- When defined, the per-bit debounce counters are instantiated and key_val behaves as described in Operation.
- When undefined, there are no counters and key_val = key_sync. DEBOUNCE_CYCLES is then ignored.
- SW is never debounced in either case.

## Structure
- package_param gains:
  - the MMIO address constants: LEDR_ADDR, LEDG_ADDR, HEX_BASE, LCD_BASE, SW_ADDR, KEY_ADDR;
  - the MMIO_REGION_MASK;
  - an enum typedef io_reg_e listing the decoded register targets.
- io_debounce is the one natural sub-module: a WIDTH-bit vector of synchroniser plus counter, parameterised by DEBOUNCE_CYCLES. io_periph instantiates it once, for KEY.

## Test plan
- Reset state: assert rst_ni = 0 mid-run after writing LEDR = 0xDEADBEEF → all io_*_o outputs read 0 immediately, with no clock edge needed.
- Masked store: store wdata 0xAABBCCDD with bmask 4'b0100 to HEX3 (0x702C) holding 0x11223344 → io_hex3_o becomes 0x11BB3344 after 1 edge, and hit_o = 1.
- Illegal stores: store to SW (0x7800) and to unmapped 0x7100 → no output changes, and a load of 0x7100 gives rdata_o = 0, hit_o = 0.
- Switch synchronisation: set io_sw_i = 0x0000_0155 → rdata_o at 0x7800 shows 0x155 two edges later and not before.
- Debounce, with IO_KEY_DEBOUNCE_EN and DEBOUNCE_CYCLES = 16:
  - a 5-cycle pulse on io_key_i[0] → the KEY read stays 0;
  - a held pulse → bit 0 reads 1 exactly 18 edges after the step.
- Read-during-write: load and store LEDG in the same cycle with old value 0x1 and new value 0x2 → rdata_o = 0x1 that cycle and 0x2 the next.
